// File: rtl/resize_patch_sched_if.sv
// Pixel-source and 2x2-patch handshake bundle for the resize patch scheduler.
// The master drives the source pixel stream. The slave (the scheduler) drives s_ready and the patch outputs.
interface resize_patch_sched_if;
   logic [7:0]  s_pix;
   logic        s_valid;
   logic        s_sof;
   logic        s_ready;
   logic [31:0] o_patch;
   logic        o_patch_valid;
   logic        o_patch_sol;
   logic        o_patch_eof;

   modport master (
      output s_pix, s_valid, s_sof,
      input  s_ready, o_patch, o_patch_valid, o_patch_sol, o_patch_eof
   );

   modport slave (
      input  s_pix, s_valid, s_sof,
      output s_ready, o_patch, o_patch_valid, o_patch_sol, o_patch_eof
   );
endinterface

// File: rtl/resize_patch_sched.sv
// Turns a raster 8-bit pixel stream into 2x2 bilinear patches using one line buffer.
// It also inserts the idle gaps at line and frame boundaries that the resize datapath needs.
module resize_patch_sched #(
   parameter int unsigned SRC_W     = 640,
   parameter int unsigned SRC_H     = 480,
   parameter int unsigned LINE_GAP  = 2,
   parameter int unsigned FRAME_GAP = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   resize_patch_sched_if.slave     bus,
   output logic                    o_busy,
   output logic                    o_err_sof
);

   localparam int unsigned CW = 12;
   localparam int unsigned AW = $clog2(SRC_W);
   localparam int unsigned GW = 16;
   localparam logic [CW-1:0] LAST_X = CW'(SRC_W - 1);
   localparam logic [CW-1:0] LAST_Y = CW'(SRC_H - 1);
   localparam logic [GW-1:0] LINE_GAP_END  = GW'(LINE_GAP - 1);
   localparam logic [GW-1:0] FRAME_GAP_END = GW'(FRAME_GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRST_LINE,
      ST_BODY,
      ST_LINE_GAP,
      ST_FRAME_GAP
   } state_t;

   state_t          state;
   logic [CW-1:0]   x;
   logic [CW-1:0]   y;
   logic [GW-1:0]   gap_cnt;
   logic [7:0]      prev_top;
   logic [7:0]      prev_bot;
   logic [7:0]      lb [SRC_W];

   logic            xfer_c;
   logic            lb_we_c;
   logic [AW-1:0]   lb_addr_c;
   logic [7:0]      lb_rd_c;

   // An accepted s_sof always restarts at column 0, whatever the current x is.
   always_comb begin
      xfer_c    = bus.s_valid & bus.s_ready;
      lb_we_c   = xfer_c & ((state == ST_FIRST_LINE) | (state == ST_BODY) | bus.s_sof);
      lb_addr_c = bus.s_sof ? '0 : x[AW-1:0];
      lb_rd_c   = lb[x[AW-1:0]];
   end

   // Line buffer: read of the old row happens in the same cycle as the overwrite.
   always_ff @(posedge i_clk) begin
      if (lb_we_c && !i_rst) begin
         lb[lb_addr_c] <= bus.s_pix;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= ST_IDLE;
         x                 <= '0;
         y                 <= '0;
         gap_cnt           <= '0;
         prev_top          <= '0;
         prev_bot          <= '0;
         bus.s_ready       <= 1'b1;
         bus.o_patch       <= '0;
         bus.o_patch_valid <= 1'b0;
         bus.o_patch_sol   <= 1'b0;
         bus.o_patch_eof   <= 1'b0;
         o_busy            <= 1'b0;
         o_err_sof         <= 1'b0;
      end else begin
         bus.o_patch_valid <= 1'b0;
         bus.o_patch_sol   <= 1'b0;
         bus.o_patch_eof   <= 1'b0;
         o_err_sof         <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (xfer_c && bus.s_sof) begin
                  x      <= CW'(1);
                  y      <= '0;
                  state  <= ST_FIRST_LINE;
                  o_busy <= 1'b1;
               end
            end

            ST_FIRST_LINE, ST_BODY: begin
               if (xfer_c) begin
                  if (bus.s_sof) begin
                     // Abort the current frame and take this pixel as (0,0) of a new one.
                     o_err_sof <= 1'b1;
                     x         <= CW'(1);
                     y         <= '0;
                     state     <= ST_FIRST_LINE;
                  end else begin
                     prev_top <= lb_rd_c;
                     prev_bot <= bus.s_pix;
                     if (state == ST_BODY && x != '0) begin
                        bus.o_patch       <= {bus.s_pix, lb_rd_c, prev_bot, prev_top};
                        bus.o_patch_valid <= 1'b1;
                        bus.o_patch_sol   <= (x == CW'(1));
                        bus.o_patch_eof   <= (x == LAST_X) && (y == LAST_Y);
                     end
                     if (x == LAST_X) begin
                        x           <= '0;
                        gap_cnt     <= '0;
                        bus.s_ready <= 1'b0;
                        state       <= (state == ST_BODY && y == LAST_Y) ? ST_FRAME_GAP : ST_LINE_GAP;
                     end else begin
                        x <= x + CW'(1);
                     end
                  end
               end
            end

            ST_LINE_GAP: begin
               if (gap_cnt == LINE_GAP_END) begin
                  state       <= ST_BODY;
                  bus.s_ready <= 1'b1;
                  y           <= y + CW'(1);
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            ST_FRAME_GAP: begin
               if (gap_cnt == FRAME_GAP_END) begin
                  state       <= ST_IDLE;
                  bus.s_ready <= 1'b1;
                  o_busy      <= 1'b0;
                  y           <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            default: begin
               state       <= ST_IDLE;
               bus.s_ready <= 1'b1;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resize_patch_sched.sv
// Directed bench for resize_patch_sched on an 8x4 frame whose pixel value is 16*y+x.
module tb_resize_patch_sched;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int LG = 2;
   localparam int FG = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic err_sof;

   resize_patch_sched_if bus();

   resize_patch_sched #(
      .SRC_W(W), .SRC_H(H), .LINE_GAP(LG), .FRAME_GAP(FG)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .bus       (bus),
      .o_busy    (busy),
      .o_err_sof (err_sof)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] patch;
      logic        sol;
      logic        eof;
      int          cyc;
   } patch_t;

   // cut_kind: 0 = none, 1 = s_sof restart at (cut_x,cut_y), 2 = i_rst at (cut_x,cut_y)
   typedef struct {
      int pct;
      int cut_kind;
      int cut_x;
      int cut_y;
      int exp_patches;
      int exp_err;
   } scen_t;

   patch_t act_q[$];
   patch_t exp_q[$];
   int     gap_q[$];
   int     cyc = 0;
   int     low_run = 0;
   int     err_cycles = 0;
   int     flag_viol = 0;
   int     passed = 0;
   int     total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.o_patch_valid)
         act_q.push_back('{bus.o_patch, bus.o_patch_sol, bus.o_patch_eof, cyc});
      else if (bus.o_patch_sol || bus.o_patch_eof)
         flag_viol <= flag_viol + 1;
      if (err_sof) err_cycles <= err_cycles + 1;
      if (!bus.s_ready) low_run <= low_run + 1;
      else if (low_run > 0) begin
         gap_q.push_back(low_run);
         low_run <= 0;
      end
   end

   function automatic logic [7:0] pix(int y, int x);
      return 8'(16 * y + x);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic bound_expired(string name);
      total++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic send_pix(int y, int x, int pct);
      int guard = 0;
      forever begin
         @(negedge clk);
         bus.s_pix = pix(y, x);
         bus.s_sof = (x == 0 && y == 0);
         if (pct > 0 && int'($urandom_range(99)) < pct) begin
            bus.s_valid = 1'b0;
         end else begin
            bus.s_valid = 1'b1;
            if (bus.s_ready) break;
         end
         guard++;
         if (guard > 100) begin
            bound_expired("send_pix");
            break;
         end
      end
      if (bus.s_valid && bus.s_ready && x >= 1 && y >= 1)
         exp_q.push_back('{{pix(y, x), pix(y-1, x), pix(y, x-1), pix(y-1, x-1)},
                           (x == 1), (x == W-1 && y == H-1), cyc + 1});
   endtask

   task automatic run_frame(int pct, int stop_x, int stop_y);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y * W + x >= stop_y * W + stop_x) return;
            send_pix(y, x, pct);
            if (y == 0 && x == 1) check("busy_in_frame", 32'(busy), 32'd1);
         end
      end
   endtask

   task automatic finish_frame();
      int guard = 0;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      while (!bus.s_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 50) begin
            bound_expired("frame_gap_end");
            break;
         end
      end
      check("busy_after_frame", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   scen_t tbl [4];

   initial begin
      int act_base, gap_base, err_base, n, m;

      tbl[0] = '{0,  0, 0, 0, 21, 0};
      tbl[1] = '{50, 0, 0, 0, 21, 0};
      tbl[2] = '{0,  1, 3, 2, 30, 1};
      tbl[3] = '{0,  2, 4, 2, 31, 0};

      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_pix   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.s_ready), 32'd1);
      check("rst_valid", 32'(bus.o_patch_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_patch", bus.o_patch, 32'd0);
      check("rst_flags", 32'({bus.o_patch_sol, bus.o_patch_eof, err_sof}), 32'd0);
      rst = 1'b0;

      // Pixels without s_sof in IDLE are dropped.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_sof   = 1'b0;
         bus.s_pix   = 8'(i + 1);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_patches", 32'(act_q.size()), 32'd0);
      check("drop_ready", 32'(bus.s_ready), 32'd1);

      for (int s = 0; s < 4; s++) begin
         exp_q.delete();
         act_base = act_q.size();
         gap_base = gap_q.size();
         err_base = err_cycles;

         if (tbl[s].cut_kind != 0) run_frame(tbl[s].pct, tbl[s].cut_x, tbl[s].cut_y);
         if (tbl[s].cut_kind == 2) begin
            @(negedge clk);
            rst         = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_sof   = 1'b0;
            bus.s_pix   = pix(tbl[s].cut_y, tbl[s].cut_x);
            @(negedge clk);
            check("midrst_valid", 32'(bus.o_patch_valid), 32'd0);
            check("midrst_ready", 32'(bus.s_ready), 32'd1);
            check("midrst_busy", 32'(busy), 32'd0);
            rst         = 1'b0;
            bus.s_valid = 1'b0;
         end
         run_frame(tbl[s].pct, 0, H);
         finish_frame();

         n = act_q.size() - act_base;
         check("patch_count", 32'(n), 32'(tbl[s].exp_patches));
         m = (n < exp_q.size()) ? n : exp_q.size();
         for (int i = 0; i < m; i++) begin
            check("patch_value", act_q[act_base+i].patch, exp_q[i].patch);
            check("patch_sol_eof", 32'({act_q[act_base+i].sol, act_q[act_base+i].eof}),
                  32'({exp_q[i].sol, exp_q[i].eof}));
            check("patch_latency", 32'(act_q[act_base+i].cyc), 32'(exp_q[i].cyc));
         end
         check("gap_count", 32'(gap_q.size() - gap_base), 32'(tbl[s].cut_y + 4));
         for (int k = gap_base; k < gap_q.size(); k++)
            check("gap_len", 32'(gap_q[k]), (k == gap_q.size() - 1) ? 32'(FG) : 32'(LG));
         check("err_sof_cycles", 32'(err_cycles - err_base), 32'(tbl[s].exp_err));

         if (s == 0 && n == 21) begin
            check("first_patch", act_q[act_base].patch, 32'h11011000);
            check("first_sol", 32'(act_q[act_base].sol), 32'd1);
            check("last_patch", act_q[act_base+20].patch, 32'h37273626);
            check("last_eof", 32'(act_q[act_base+20].eof), 32'd1);
         end
      end

      check("flags_without_valid", 32'(flag_viol), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
